ex_alu_stage: RTL and testbench

Execute-stage datapath block of the five-stage RISC-V pipeline.
- Consumes the 3-bit ALU control code produced by the ALU decoder, together with the ID/EX operands and control bits.
- Computes the ALU result and the branch-taken decision.
- Owns the EX/MEM pipeline register, including stall/flush handling and a valid bit.
- Optionally contains a multi-cycle iterative shifter that stalls the front of the pipeline while it runs.

---
 rtl/ex_alu_stage.sv | 185 ++++++++++++++++++
 tb/tb_ex_alu_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU, branch decision and the EX/MEM pipeline register.
// Define EX_SHIFT_EN to build the iterative 1-bit/cycle shifter for codes 110/111.
module ex_alu_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ValidE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [2:0]       ALUControlE,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic [4:0]       RdE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [WIDTH-1:0] PCPlus4E,
    input  logic             FlushE,
    input  logic             StallM,
    input  logic             FlushM,
    output logic             ZeroE,
    output logic             PCSrcE,
    output logic             BusyE,
    output logic             ValidM,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [4:0]       RdM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] PCPlus4M
);

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] shift_result;
    logic             cap_valid;

    assign diff   = SrcAE - SrcBE;
    assign ZeroE  = (diff == '0);
    assign PCSrcE = ValidE & ~FlushE & (JumpE | (BranchE & ZeroE));

`ifdef EX_SHIFT_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} sh_state_t;

    sh_state_t        state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             is_shift;

    assign is_shift     = ValidE & (ALUControlE[2:1] == 2'b11);
    assign BusyE        = is_shift & (state_q != S_DONE);
    assign shift_result = acc_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (FlushE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_shift) begin
                        acc_d   = SrcAE;
                        cnt_d   = SrcBE[4:0];
                        state_d = (SrcBE[4:0] == 5'd0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc_d = ALUControlE[0] ? (acc_q >> 1) : (acc_q << 1);
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) state_d = S_DONE;
                end
                // Hold the finished result until EX/MEM actually takes it.
                S_DONE: begin
                    if (!StallM) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign BusyE        = 1'b0;
    assign shift_result = '0;
`endif

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            3'b000:         alu_result = SrcAE + SrcBE;
            3'b001:         alu_result = diff;
            3'b010:         alu_result = SrcAE & SrcBE;
            3'b011:         alu_result = SrcAE | SrcBE;
            3'b100:         alu_result = SrcAE ^ SrcBE;
            3'b101:         alu_result = {{(WIDTH-1){1'b0}}, ($signed(SrcAE) < $signed(SrcBE))};
            3'b110, 3'b111: alu_result = shift_result;
            default:        alu_result = '0;
        endcase
    end

    // EX/MEM register
    logic             valid_m_q, valid_m_d;
    logic             regwrite_m_q, regwrite_m_d;
    logic             memwrite_m_q, memwrite_m_d;
    logic [1:0]       resultsrc_m_q, resultsrc_m_d;
    logic [4:0]       rd_m_q, rd_m_d;
    logic [WIDTH-1:0] aluresult_m_q, aluresult_m_d;
    logic [WIDTH-1:0] writedata_m_q, writedata_m_d;
    logic [WIDTH-1:0] pcplus4_m_q, pcplus4_m_d;

    // A killed or still-busy instruction enters M as a bubble with no side effects.
    assign cap_valid = ValidE & ~FlushE & ~BusyE;

    always_comb begin
        valid_m_d     = valid_m_q;
        regwrite_m_d  = regwrite_m_q;
        memwrite_m_d  = memwrite_m_q;
        resultsrc_m_d = resultsrc_m_q;
        rd_m_d        = rd_m_q;
        aluresult_m_d = aluresult_m_q;
        writedata_m_d = writedata_m_q;
        pcplus4_m_d   = pcplus4_m_q;
        if (FlushM) begin
            valid_m_d    = 1'b0;
            regwrite_m_d = 1'b0;
            memwrite_m_d = 1'b0;
        end else if (!StallM) begin
            valid_m_d     = cap_valid;
            regwrite_m_d  = RegWriteE & cap_valid;
            memwrite_m_d  = MemWriteE & cap_valid;
            resultsrc_m_d = ResultSrcE;
            rd_m_d        = RdE;
            aluresult_m_d = alu_result;
            writedata_m_d = WriteDataE;
            pcplus4_m_d   = PCPlus4E;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_m_q     <= 1'b0;
            regwrite_m_q  <= 1'b0;
            memwrite_m_q  <= 1'b0;
            resultsrc_m_q <= '0;
            rd_m_q        <= '0;
            aluresult_m_q <= '0;
            writedata_m_q <= '0;
            pcplus4_m_q   <= '0;
        end else begin
            valid_m_q     <= valid_m_d;
            regwrite_m_q  <= regwrite_m_d;
            memwrite_m_q  <= memwrite_m_d;
            resultsrc_m_q <= resultsrc_m_d;
            rd_m_q        <= rd_m_d;
            aluresult_m_q <= aluresult_m_d;
            writedata_m_q <= writedata_m_d;
            pcplus4_m_q   <= pcplus4_m_d;
        end
    end

    assign ValidM     = valid_m_q;
    assign RegWriteM  = regwrite_m_q;
    assign MemWriteM  = memwrite_m_q;
    assign ResultSrcM = resultsrc_m_q;
    assign RdM        = rd_m_q;
    assign ALUResultM = aluresult_m_q;
    assign WriteDataM = writedata_m_q;
    assign PCPlus4M   = pcplus4_m_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: cycle model + per-cycle compare, plus literal checks.
// Shifter checks are built when EX_SHIFT_EN is defined, otherwise the 110/111 = 0 path is checked.
module tb_ex_alu_stage;

    logic        clk;
    logic        reset_n;
    logic        ValidE;
    logic [31:0] SrcAE, SrcBE;
    logic [2:0]  ALUControlE;
    logic        BranchE, JumpE, RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE;
    logic [4:0]  RdE;
    logic [31:0] WriteDataE, PCPlus4E;
    logic        FlushE, StallM, FlushM;
    logic        ZeroE, PCSrcE, BusyE;
    logic        ValidM, RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    ex_alu_stage #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .ValidE(ValidE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
        .BranchE(BranchE), .JumpE(JumpE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .RdE(RdE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
        .FlushE(FlushE), .StallM(StallM), .FlushM(FlushM),
        .ZeroE(ZeroE), .PCSrcE(PCSrcE), .BusyE(BusyE),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RdM(RdM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int txn   = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: the expected contents of M, plus an abstract "shift in flight" record
    logic        m_valid = 0, m_rw = 0, m_mw = 0;
    logic [1:0]  m_rs = 0;
    logic [4:0]  m_rd = 0;
    logic [31:0] m_alu = 0, m_wd = 0, m_pc4 = 0;
    bit          sh_active = 0;
    int          sh_left = 0;
    logic [31:0] sh_result = 0;

    function automatic logic model_busy();
`ifdef EX_SHIFT_EN
        if (!(ValidE && ALUControlE[2:1] == 2'b11)) return 1'b0;
        if (!sh_active) return 1'b1;
        return (sh_left != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_alu();
        case (ALUControlE)
            3'd0: return SrcAE + SrcBE;
            3'd1: return SrcAE - SrcBE;
            3'd2: return SrcAE & SrcBE;
            3'd3: return SrcAE | SrcBE;
            3'd4: return SrcAE ^ SrcBE;
            3'd5: return ($signed(SrcAE) < $signed(SrcBE)) ? 32'd1 : 32'd0;
`ifdef EX_SHIFT_EN
            default: return sh_result;
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_valid <= 0; m_rw <= 0; m_mw <= 0; m_rs <= 0; m_rd <= 0;
            m_alu <= 0; m_wd <= 0; m_pc4 <= 0;
            sh_active <= 0; sh_left <= 0;
        end else begin
`ifdef EX_SHIFT_EN
            if (FlushE) begin
                sh_active <= 0;
            end else if (ValidE && ALUControlE[2:1] == 2'b11) begin
                if (!sh_active) begin
                    sh_active <= 1;
                    sh_left   <= int'(SrcBE[4:0]);
                    sh_result <= ALUControlE[0] ? (SrcAE >> SrcBE[4:0]) : (SrcAE << SrcBE[4:0]);
                end else if (sh_left != 0) begin
                    sh_left <= sh_left - 1;
                end else if (!StallM) begin
                    sh_active <= 0;
                end
            end
`endif
            if (FlushM) begin
                m_valid <= 0; m_rw <= 0; m_mw <= 0;
            end else if (!StallM) begin
                m_valid <= ValidE & ~FlushE & ~model_busy();
                m_rw    <= RegWriteE & ValidE & ~FlushE & ~model_busy();
                m_mw    <= MemWriteE & ValidE & ~FlushE & ~model_busy();
                m_rs    <= ResultSrcE;
                m_rd    <= RdE;
                m_alu   <= model_alu();
                m_wd    <= WriteDataE;
                m_pc4   <= PCPlus4E;
            end
        end
    end

    // Compare process: combinational outputs and M register every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ZeroE", ZeroE, SrcAE == SrcBE);
            chk("PCSrcE", PCSrcE, ValidE & ~FlushE & (JumpE | (BranchE & (SrcAE == SrcBE))));
            chk("BusyE", BusyE, model_busy());
            chk("ValidM", ValidM, m_valid);
            chk("RegWriteM", RegWriteM, m_rw);
            chk("MemWriteM", MemWriteM, m_mw);
            if (m_valid) begin
                chk("ResultSrcM", ResultSrcM, m_rs);
                chk("RdM", RdM, m_rd);
                chk("ALUResultM", ALUResultM, m_alu);
                chk("WriteDataM", WriteDataM, m_wd);
                chk("PCPlus4M", PCPlus4M, m_pc4);
            end
        end
    end

    task automatic idle();
        ValidE = 0; SrcAE = 0; SrcBE = 0; ALUControlE = 0;
        BranchE = 0; JumpE = 0; RegWriteE = 0; MemWriteE = 0;
        ResultSrcE = 0; RdE = 0; WriteDataE = 0; PCPlus4E = 0;
        FlushE = 0; StallM = 0; FlushM = 0;
    endtask

    task automatic set_ex(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        txn++;
        ValidE = 1; ALUControlE = op; SrcAE = a; SrcBE = b;
        BranchE = 0; JumpE = 0; FlushE = 0; StallM = 0; FlushM = 0;
        RegWriteE = 1; MemWriteE = txn[0]; ResultSrcE = op[1:0];
        RdE = txn[4:0]; WriteDataE = ~a; PCPlus4E = 32'h1000 + 32'(txn * 4);
        $display("txn %0d op=%b a=%h b=%h", txn, op, a, b);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

`ifdef EX_SHIFT_EN
    task automatic run_shift(input string nm, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int exp_busy, input logic [31:0] exp_res);
        int busy_cnt;
        busy_cnt = 0;
        set_ex(op, a, b);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (BusyE) busy_cnt++;
            else break;
        end
        chk({nm, "_busy_cycles"}, busy_cnt, exp_busy);
        step();
        idle();
        chk({nm, "_valid"}, ValidM, 1'b1);
        chk({nm, "_result"}, ALUResultM, exp_res);
    endtask
`endif

    logic [2:0]  tv_op  [8] = '{3'd0, 3'd1, 3'd5, 3'd5, 3'd2, 3'd3, 3'd4, 3'd1};
    logic [31:0] tv_a   [8] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF,
                                32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h00000000};
    logic [31:0] tv_b   [8] = '{32'h1, 32'h1, 32'h1, 32'h0,
                                32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h1};
    logic [31:0] tv_exp [8] = '{32'h80000000, 32'h7FFFFFFE, 32'h0, 32'h1,
                                32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'hFFFFFFFF};

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 0;
        ValidE = 1'($urandom_range(0, 1)); SrcAE = $urandom; SrcBE = $urandom;
        ALUControlE = 3'($urandom_range(0, 7)); BranchE = 1'($urandom_range(0, 1));
        JumpE = 1'($urandom_range(0, 1)); RegWriteE = 1; MemWriteE = 1;
        ResultSrcE = 2'($urandom_range(0, 3)); RdE = 5'($urandom_range(0, 31));
        WriteDataE = $urandom; PCPlus4E = $urandom;
        FlushE = 0; StallM = 0; FlushM = 0;
        @(posedge clk);
        chk_en = 1;
        step();
        chk("rst_ValidM", ValidM, 1'b0);
        chk("rst_RegWriteM", RegWriteM, 1'b0);
        chk("rst_MemWriteM", MemWriteM, 1'b0);
        chk("rst_ALUResultM", ALUResultM, 32'h0);
        chk("rst_PCPlus4M", PCPlus4M, 32'h0);
        chk("rst_RdM", RdM, 32'h0);
        idle();
        #1;
        chk("rst_BusyE", BusyE, 1'b0);
        reset_n = 1;
        step();
        step();
        chk("post_rst_ValidM", ValidM, 1'b0);

        // ALU ops with hand-computed results
        for (int i = 0; i < 8; i++) begin
            set_ex(tv_op[i], tv_a[i], tv_b[i]);
            step();
            chk($sformatf("alu_vec%0d_valid", i), ValidM, 1'b1);
            chk($sformatf("alu_vec%0d_result", i), ALUResultM, tv_exp[i]);
        end

        // Branch decision
        set_ex(3'd1, 32'd5, 32'd5);
        RegWriteE = 0; BranchE = 1;
        #1;
        chk("beq_ZeroE", ZeroE, 1'b1);
        chk("beq_PCSrcE", PCSrcE, 1'b1);
        FlushE = 1;
        #1;
        chk("beq_flush_PCSrcE", PCSrcE, 1'b0);
        step();
        chk("beq_flush_ValidM", ValidM, 1'b0);
        set_ex(3'd0, 32'd5, 32'd6);
        JumpE = 1;
        #1;
        chk("jal_ZeroE", ZeroE, 1'b0);
        chk("jal_PCSrcE", PCSrcE, 1'b1);
        step();

        // Stall holds M, flush beats stall
        set_ex(3'd0, 32'd1, 32'd2);
        step();
        chk("pre_stall_result", ALUResultM, 32'd3);
        set_ex(3'd0, 32'd10, 32'd10);
        StallM = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_result", ALUResultM, 32'd3);
            chk("stall_valid", ValidM, 1'b1);
        end
        FlushM = 1;
        step();
        chk("flush_stall_ValidM", ValidM, 1'b0);
        chk("flush_stall_RegWriteM", RegWriteM, 1'b0);
        idle();
        step();

`ifdef EX_SHIFT_EN
        run_shift("sll4", 3'd6, 32'h00000003, 32'd4, 5, 32'h00000030);
        run_shift("srl31", 3'd7, 32'h80000000, 32'd31, 32, 32'h00000001);
        run_shift("shamt0", 3'd6, 32'hDEADBEEF, 32'h00000020, 1, 32'hDEADBEEF);

        // Abort in the second SHIFT cycle
        set_ex(3'd6, 32'h1, 32'd4);
        step();
        step();
        FlushE = 1;
        step();
        chk("abort_ValidM", ValidM, 1'b0);
        set_ex(3'd0, 32'd2, 32'd3);
        #1;
        chk("abort_next_BusyE", BusyE, 1'b0);
        step();
        chk("abort_next_valid", ValidM, 1'b1);
        chk("abort_next_result", ALUResultM, 32'd5);

        // Reset mid-shift
        set_ex(3'd7, 32'hF0000000, 32'd10);
        step();
        step();
        step();
        reset_n = 0;
        idle();
        step();
        chk("midrst_ValidM", ValidM, 1'b0);
        chk("midrst_ALUResultM", ALUResultM, 32'h0);
        reset_n = 1;
        run_shift("after_rst_srl", 3'd7, 32'hF0000000, 32'd2, 3, 32'h3C000000);
`else
        set_ex(3'd6, 32'h5, 32'h1);
        #1;
        chk("noshift_sll_BusyE", BusyE, 1'b0);
        step();
        chk("noshift_sll_valid", ValidM, 1'b1);
        chk("noshift_sll_result", ALUResultM, 32'h0);
        set_ex(3'd7, 32'h80000000, 32'h1);
        step();
        chk("noshift_srl_result", ALUResultM, 32'h0);
`endif
        idle();
        step();
        step();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
